// File: rtl/btb_pkg.sv
// btb_pkg -- shared types and constants for the branch target buffer.
//   btb_ctr_e : 2-bit saturating direction counter encoding
//   CTR_RESET : counter value loaded into every entry on reset
//   CTR_ALLOC : counter value given to a freshly allocated entry
//   ctr_next  : saturating increment (taken) / decrement (not taken)
package btb_pkg;

   typedef enum logic [1:0] {
      STRONG_NT = 2'b00,
      WEAK_NT   = 2'b01,
      WEAK_T    = 2'b10,
      STRONG_T  = 2'b11
   } btb_ctr_e;

   localparam btb_ctr_e CTR_RESET = WEAK_NT;
   localparam btb_ctr_e CTR_ALLOC = WEAK_T;

   function automatic btb_ctr_e ctr_next(input btb_ctr_e cur, input logic taken);
      btb_ctr_e nxt;
      nxt = cur;
      case (cur)
         STRONG_NT: nxt = taken ? WEAK_NT  : STRONG_NT;
         WEAK_NT:   nxt = taken ? WEAK_T   : STRONG_NT;
         WEAK_T:    nxt = taken ? STRONG_T : WEAK_NT;
         STRONG_T:  nxt = taken ? STRONG_T : WEAK_T;
         default:   nxt = cur;
      endcase
      return nxt;
   endfunction

endpackage

// File: rtl/btb_stats.sv
// btb_stats -- wrapping 32-bit performance counters for the BTB.
// Ports:
//   clk, rst          : clock, synchronous active-high reset (zeroes counters)
//   lookup_valid      : +1 to stat_lookups per cycle
//   upd_valid         : +1 to stat_updates per cycle
//   upd_mispredict    : with upd_valid, +1 to stat_mispredicts
//   stat_*            : current counter values
module btb_stats (
   input  logic        clk,
   input  logic        rst,
   input  logic        lookup_valid,
   input  logic        upd_valid,
   input  logic        upd_mispredict,
   output logic [31:0] stat_lookups,
   output logic [31:0] stat_updates,
   output logic [31:0] stat_mispredicts
);

   logic [31:0] lookups_q, updates_q, mispredicts_q;

   always_ff @(posedge clk) begin
      if (rst) begin
         lookups_q     <= 32'd0;
         updates_q     <= 32'd0;
         mispredicts_q <= 32'd0;
      end else begin
         // Plain +1 wraps 0xFFFFFFFF -> 0.
         if (lookup_valid) lookups_q <= lookups_q + 32'd1;
         if (upd_valid) updates_q <= updates_q + 32'd1;
         if (upd_valid && upd_mispredict) mispredicts_q <= mispredicts_q + 32'd1;
      end
   end

   assign stat_lookups     = lookups_q;
   assign stat_updates     = updates_q;
   assign stat_mispredicts = mispredicts_q;

endmodule

// File: rtl/btb_predictor.sv
// btb_predictor -- direct-mapped branch target buffer with 2-bit counters.
// Lookup is combinational on if_pc; updates from EX write on the rising edge.
// No bypass: a same-cycle update to the looked-up entry shows up next cycle.
// Optional feature: define BTB_STATS_EN to build the statistics counters;
// otherwise stat_* are tied to zero.
// Ports:
//   clk, rst                      : clock, synchronous active-high reset
//   lookup_valid                  : live fetch (gates statistics only)
//   if_pc                         : fetch PC
//   pred_hit/pred_taken/pred_target : prediction for if_pc
//   upd_valid/upd_pc/upd_taken/upd_target/upd_mispredict : resolved branch
//   stat_lookups/stat_updates/stat_mispredicts : performance counters
module btb_predictor
   import btb_pkg::*;
#(
   parameter int unsigned XLEN    = 64,
   parameter int unsigned ENTRIES = 16,
   parameter int unsigned TAG_W   = 8
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            lookup_valid,
   input  logic [XLEN-1:0] if_pc,
   output logic            pred_hit,
   output logic            pred_taken,
   output logic [XLEN-1:0] pred_target,
   input  logic            upd_valid,
   input  logic [XLEN-1:0] upd_pc,
   input  logic            upd_taken,
   input  logic [XLEN-1:0] upd_target,
   input  logic            upd_mispredict,
   output logic [31:0]     stat_lookups,
   output logic [31:0]     stat_updates,
   output logic [31:0]     stat_mispredicts
);

   localparam int unsigned IDX_W = $clog2(ENTRIES);

   typedef struct packed {
      logic             valid;
      logic [TAG_W-1:0] tag;
      logic [XLEN-1:0]  target;
      btb_ctr_e         ctr;
   } entry_t;

   entry_t table_q [ENTRIES];

   logic [IDX_W-1:0] lk_idx, up_idx;
   logic [TAG_W-1:0] lk_tag, up_tag;
   entry_t           lk_entry, up_entry, upd_entry;
   logic             lk_hit, up_hit, upd_we;

   assign lk_idx = if_pc[IDX_W+1:2];
   assign lk_tag = if_pc[IDX_W+1+TAG_W:IDX_W+2];
   assign up_idx = upd_pc[IDX_W+1:2];
   assign up_tag = upd_pc[IDX_W+1+TAG_W:IDX_W+2];

   assign lk_entry = table_q[lk_idx];
   assign up_entry = table_q[up_idx];
   assign lk_hit   = lk_entry.valid && (lk_entry.tag == lk_tag);
   assign up_hit   = up_entry.valid && (up_entry.tag == up_tag);

   // Prediction is forced to fall-through while in reset.
   assign pred_hit    = !rst && lk_hit;
   assign pred_taken  = pred_hit && lk_entry.ctr[1];
   assign pred_target = pred_taken ? lk_entry.target : if_pc + XLEN'(4);

   always_comb begin
      upd_we    = 1'b0;
      upd_entry = up_entry;
      if (upd_valid) begin
         if (up_hit) begin
            upd_we        = 1'b1;
            upd_entry.ctr = ctr_next(up_entry.ctr, upd_taken);
            if (upd_taken) upd_entry.target = upd_target;
         end else if (upd_taken) begin
            // Not-taken misses never allocate.
            upd_we           = 1'b1;
            upd_entry.valid  = 1'b1;
            upd_entry.tag    = up_tag;
            upd_entry.target = upd_target;
            upd_entry.ctr    = CTR_ALLOC;
         end
      end
   end

   // Tag/target are left unreset; valid=0 masks them.
   always_ff @(posedge clk) begin
      if (rst) begin
         for (int unsigned i = 0; i < ENTRIES; i++) begin
            table_q[IDX_W'(i)].valid <= 1'b0;
            table_q[IDX_W'(i)].ctr   <= CTR_RESET;
         end
      end else if (upd_we) begin
         table_q[up_idx] <= upd_entry;
      end
   end

   // Upper/lower PC bits are intentionally ignored by indexing.
   logic unused_bits;
   assign unused_bits = ^{if_pc, upd_pc, lookup_valid, upd_mispredict};

`ifdef BTB_STATS_EN
   btb_stats u_stats (
      .clk              (clk),
      .rst              (rst),
      .lookup_valid     (lookup_valid),
      .upd_valid        (upd_valid),
      .upd_mispredict   (upd_mispredict),
      .stat_lookups     (stat_lookups),
      .stat_updates     (stat_updates),
      .stat_mispredicts (stat_mispredicts)
   );
`else
   assign stat_lookups     = 32'd0;
   assign stat_updates     = 32'd0;
   assign stat_mispredicts = 32'd0;
`endif

endmodule

// File: tb/tb_btb_predictor.sv
// Directed bench for btb_predictor (XLEN=64, ENTRIES=16, TAG_W=8).
module tb_btb_predictor;

   logic        clk = 1'b0;
   logic        rst;
   logic        lookup_valid;
   logic [63:0] if_pc;
   logic        pred_hit, pred_taken;
   logic [63:0] pred_target;
   logic        upd_valid;
   logic [63:0] upd_pc;
   logic        upd_taken;
   logic [63:0] upd_target;
   logic        upd_mispredict;
   logic [31:0] stat_lookups, stat_updates, stat_mispredicts;

   int total = 0;
   int bad   = 0;

   btb_predictor #(.XLEN(64), .ENTRIES(16), .TAG_W(8)) dut (
      .clk              (clk),
      .rst              (rst),
      .lookup_valid     (lookup_valid),
      .if_pc            (if_pc),
      .pred_hit         (pred_hit),
      .pred_taken       (pred_taken),
      .pred_target      (pred_target),
      .upd_valid        (upd_valid),
      .upd_pc           (upd_pc),
      .upd_taken        (upd_taken),
      .upd_target       (upd_target),
      .upd_mispredict   (upd_mispredict),
      .stat_lookups     (stat_lookups),
      .stat_updates     (stat_updates),
      .stat_mispredicts (stat_mispredicts)
   );

   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic pred(input string tag, input logic h, input logic t, input logic [63:0] tgt);
      check({tag, "_hit"}, {63'd0, pred_hit}, {63'd0, h});
      check({tag, "_taken"}, {63'd0, pred_taken}, {63'd0, t});
      check({tag, "_target"}, pred_target, tgt);
   endtask

   task automatic upd(input logic v, input logic [63:0] pc, input logic tk,
                      input logic [63:0] tgt, input logic mp);
      upd_valid      = v;
      upd_pc         = pc;
      upd_taken      = tk;
      upd_target     = tgt;
      upd_mispredict = mp;
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: observed=timeout expected=finish");
      $fatal(1, "watchdog expired");
   end

   initial begin
      logic [31:0] exp_lk, exp_up, exp_mp;

      // Reset with a simultaneous update that must be discarded.
      rst = 1'b1;
      lookup_valid = 1'b0;
      if_pc = 64'h40;
      upd(1'b1, 64'h40, 1'b1, 64'h200, 1'b0);
      #1;
      pred("in_rst", 1'b0, 1'b0, 64'h44);
      tick();
      tick();
      pred("in_rst2", 1'b0, 1'b0, 64'h44);
      rst = 1'b0;
      upd(1'b0, 64'h0, 1'b0, 64'h0, 1'b0);
      tick();
      pred("cold", 1'b0, 1'b0, 64'h44);

      // Allocate 0x40 -> 0x100; same-cycle lookup still sees the miss.
      upd(1'b1, 64'h40, 1'b1, 64'h100, 1'b0);
      #1;
      pred("alloc_same_cyc", 1'b0, 1'b0, 64'h44);
      tick();
      upd_valid = 1'b0;
      pred("alloc", 1'b1, 1'b1, 64'h100);

      // Not-taken update: same cycle returns old contents.
      upd(1'b1, 64'h40, 1'b0, 64'h0, 1'b0);
      #1;
      pred("conflict_old", 1'b1, 1'b1, 64'h100);
      tick();                                    // 10 -> 01
      pred("nt1", 1'b1, 1'b0, 64'h44);
      tick();                                    // 01 -> 00
      pred("nt2", 1'b1, 1'b0, 64'h44);
      tick();                                    // 00 stays 00
      upd(1'b1, 64'h40, 1'b1, 64'h300, 1'b0);
      tick();                                    // 00 -> 01
      pred("sat_lo", 1'b1, 1'b0, 64'h44);
      upd(1'b1, 64'h40, 1'b1, 64'h340, 1'b0);
      tick();                                    // 01 -> 10, target 0x340
      pred("tk_retarget", 1'b1, 1'b1, 64'h340);
      tick();                                    // 10 -> 11
      tick();                                    // 11 stays 11
      upd(1'b1, 64'h40, 1'b0, 64'h0, 1'b0);
      tick();                                    // 11 -> 10
      upd_valid = 1'b0;
      pred("sat_hi", 1'b1, 1'b1, 64'h340);

      // Aliasing: 0x80 shares index 0 with tag 2.
      upd(1'b1, 64'h80, 1'b1, 64'h500, 1'b0);
      tick();
      upd_valid = 1'b0;
      #1;
      pred("alias_old", 1'b0, 1'b0, 64'h44);
      if_pc = 64'h80;
      #1;
      pred("alias_new", 1'b1, 1'b1, 64'h500);
      if_pc = 64'h84;
      #1;
      pred("other_idx", 1'b0, 1'b0, 64'h88);

      // Not-taken miss does not allocate.
      upd(1'b1, 64'h1044, 1'b0, 64'h900, 1'b0);
      tick();
      upd_valid = 1'b0;
      if_pc = 64'h1044;
      #1;
      pred("no_alloc", 1'b0, 1'b0, 64'h1048);

      // Fall-through wraps modulo 2^64.
      if_pc = 64'hFFFF_FFFF_FFFF_FFFC;
      #1;
      pred("pc_wrap", 1'b0, 1'b0, 64'h0);

      // Reset clears table; update during reset is dropped.
      if_pc = 64'h80;
      rst = 1'b1;
      upd(1'b1, 64'h80, 1'b1, 64'h600, 1'b0);
      tick();
      rst = 1'b0;
      upd_valid = 1'b0;
      #1;
      pred("rst_clear", 1'b0, 1'b0, 64'h84);

      // Fresh allocation starts at weak-taken: one NT makes it not-taken.
      upd(1'b1, 64'h80, 1'b1, 64'h700, 1'b0);
      tick();
      pred("realloc", 1'b1, 1'b1, 64'h700);
      upd(1'b1, 64'h80, 1'b0, 64'h0, 1'b0);
      tick();
      upd_valid = 1'b0;
      pred("realloc_nt", 1'b1, 1'b0, 64'h84);

      // Statistics: 5 lookups, 3 updates, 1 mispredict.
      rst = 1'b1;
      tick();
      rst = 1'b0;
      lookup_valid = 1'b1;
      for (int i = 0; i < 5; i++) tick();
      lookup_valid = 1'b0;
      upd(1'b1, 64'h1000, 1'b0, 64'h0, 1'b0);
      tick();
      upd(1'b1, 64'h1000, 1'b0, 64'h0, 1'b1);
      tick();
      upd(1'b1, 64'h1000, 1'b0, 64'h0, 1'b0);
      tick();
      upd(1'b0, 64'h0, 1'b0, 64'h0, 1'b0);
`ifdef BTB_STATS_EN
      exp_lk = 32'd5;
      exp_up = 32'd3;
      exp_mp = 32'd1;
`else
      exp_lk = 32'd0;
      exp_up = 32'd0;
      exp_mp = 32'd0;
`endif
      check("stat_lookups", {32'd0, stat_lookups}, {32'd0, exp_lk});
      check("stat_updates", {32'd0, stat_updates}, {32'd0, exp_up});
      check("stat_mispredicts", {32'd0, stat_mispredicts}, {32'd0, exp_mp});

`ifdef BTB_STATS_EN
      force dut.u_stats.lookups_q = 32'hFFFF_FFFF;
      #1;
      release dut.u_stats.lookups_q;
      check("stat_preload", {32'd0, stat_lookups}, 64'hFFFF_FFFF);
      lookup_valid = 1'b1;
      tick();
      lookup_valid = 1'b0;
      check("stat_wrap", {32'd0, stat_lookups}, 64'h0);
`endif

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/btb_predictor.md
BTB_PREDICTOR -- requirements
Module: btb_predictor

Interface
REQ-001 SHALL have parameter XLEN, default 64: PC and target width.
REQ-002 SHALL have parameter ENTRIES, default 16: direct-mapped table depth, power of two, at least 2.
REQ-003 SHALL have parameter TAG_W, default 8: stored tag bits, range 1..XLEN-log2(ENTRIES)-2.
REQ-004 SHALL have port clk, input, 1: the single clock; all state updates on its rising edge.
REQ-005 SHALL have port rst, input, 1: reset, synchronous, active-high.
REQ-006 SHALL have port lookup_valid, input, 1: the IF stage presents a live fetch PC.
REQ-007 SHALL have port if_pc, input, XLEN: fetch PC to predict.
REQ-008 SHALL have port pred_hit, output, 1: the BTB entry matches if_pc.
REQ-009 SHALL have port pred_taken, output, 1: predicted taken.
REQ-010 SHALL have port pred_target, output, XLEN: predicted next PC.
REQ-011 SHALL have port upd_valid, input, 1: a branch resolved in EX this cycle.
REQ-012 SHALL have port upd_pc, input, XLEN: PC of the resolved branch.
REQ-013 SHALL have port upd_taken, input, 1: resolved direction.
REQ-014 SHALL have port upd_target, input, XLEN: resolved taken target.
REQ-015 SHALL have port upd_mispredict, input, 1: EX detected a misprediction.
REQ-016 SHALL have ports stat_lookups, stat_updates and stat_mispredicts, each output, 32: performance counters.

Function
REQ-017 SHALL use index = pc[IDX_W+1:2] with IDX_W = log2(ENTRIES), and tag = pc[IDX_W+1+TAG_W : IDX_W+2].
REQ-018 SHALL hold per entry: valid, tag, target (XLEN) and a 2-bit saturating counter.
REQ-019 SHALL perform lookup combinationally with zero latency: pred_hit = valid && tag match at index(if_pc).
REQ-020 SHALL drive pred_taken = pred_hit && counter[1].
REQ-021 SHALL drive pred_target = stored target when pred_taken, else if_pc+4 (modulo 2^XLEN).
REQ-022 SHALL update an entry hit by upd_pc on rising edge when upd_valid: taken increments the counter, saturating at 11; not-taken decrements it, saturating at 00; taken also overwrites target.
REQ-023 SHALL, on upd_valid with a miss and upd_taken=1, allocate or overwrite the indexed entry: valid=1, new tag, target=upd_target, counter=10.
REQ-024 SHALL NOT allocate on upd_valid with a miss and upd_taken=0; table unchanged.
REQ-025 SHALL give lookup priority to old state when lookup and update hit the same index in one cycle: no bypass, so lookup returns pre-update contents and the update is visible the next cycle.
REQ-026 SHALL ignore lookup_valid for the prediction outputs; it gates statistics only.

Reset
REQ-027 SHALL, with rst high at a rising edge, clear all valid bits, set all counters to 01, and zero all stat counters.
REQ-028 SHALL, while rst is high, drive pred_hit=0, pred_taken=0 and pred_target=if_pc+4.
REQ-029 SHALL give rst priority over a simultaneous upd_valid: the update is discarded.

Configuration
REQ-030 SHALL include the counters only when macro BTB_STATS_EN is defined: stat_lookups +1 per cycle with lookup_valid, stat_updates +1 per upd_valid, stat_mispredicts +1 per upd_valid&&upd_mispredict; each wraps 0xFFFFFFFF->0.
REQ-031 SHALL, without BTB_STATS_EN, keep the stat ports present, tie them to constant 0, and synthesise no counter flops.

Structure
REQ-032 SHALL place in shared package btb_pkg the 2-bit counter enum (STRONG_NT=00, WEAK_NT=01, WEAK_T=10, STRONG_T=11) and the reset and allocate counter constants.
REQ-033 SHALL implement the statistics in one sub-module btb_stats, instantiated only under BTB_STATS_EN.
REQ-034 SHALL compute the parameter-dependent entry struct locally from XLEN, TAG_W and ENTRIES, not in the package.

Verification (ENTRIES=16, TAG_W=8)
REQ-035 SHALL cover cold table: after reset, if_pc=0x40 -> pred_hit=0, pred_taken=0, pred_target=0x44.
REQ-036 SHALL cover allocate: upd_valid, upd_pc=0x40, upd_taken=1, upd_target=0x100 -> next cycle if_pc=0x40 gives hit=1, taken=1, target=0x100.
REQ-037 SHALL cover saturation: two not-taken updates on 0x40 after allocate -> counter 00, pred_taken=0, pred_target=0x44; a third not-taken update leaves it at 00.
REQ-038 SHALL cover aliasing: allocate 0x40 then a taken update on 0x80 (same index 0, tag 2) -> 0x40 now misses and 0x80 hits with the new target.
REQ-039 SHALL cover same-cycle conflict and reset: lookup and update on 0x40 in one cycle return old contents; an update asserted together with rst is discarded.
REQ-040 SHALL cover stats (BTB_STATS_EN): 5 lookup_valid cycles plus 3 updates with 1 mispredict -> 5/3/1; a counter preloaded via force to 0xFFFFFFFF wraps to 0.
